// File: rtl/adder_bist_pkg.sv
// Shared definitions for the adder BIST controller: FSM state encoding and
// default geometry, used by the controller, its register-map wrapper and the bench.
package adder_bist_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_CHECK = 2'd2,
    ST_DONE  = 2'd3
  } bist_state_e;

  localparam int DEF_WIDTH         = 8;
  localparam int DEF_SETTLE_CYCLES = 1;

endpackage

// File: rtl/adder_bist_sweep.sv
// Two-level operand counter for the adder BIST: operand0 is the fast digit,
// operand1 the slow digit; last flags the final (max, max) vector.
module adder_bist_sweep
  import adder_bist_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             advance,
  output logic [WIDTH-1:0] operand0,
  output logic [WIDTH-1:0] operand1,
  output logic             last
);

  logic [WIDTH-1:0] op0_d, op0_q;
  logic [WIDTH-1:0] op1_d, op1_q;

  // Next operand pair: clear wins over advance; operand0 wrap carries into operand1.
  always_comb begin
    op0_d = op0_q;
    op1_d = op1_q;
    if (clear) begin
      op0_d = '0;
      op1_d = '0;
    end else if (advance) begin
      if (op0_q == {WIDTH{1'b1}}) begin
        op0_d = '0;
        op1_d = op1_q + WIDTH'(1);
      end else begin
        op0_d = op0_q + WIDTH'(1);
      end
    end
  end

  // Operand registers; these directly drive the adder under test.
  always_ff @(posedge clk) begin
    if (rst) begin
      op0_q <= '0;
      op1_q <= '0;
    end else begin
      op0_q <= op0_d;
      op1_q <= op1_d;
    end
  end

  assign operand0 = op0_q;
  assign operand1 = op1_q;
  assign last     = (&op0_q) & (&op1_q);

endmodule

// File: rtl/adder_bist.sv
// Built-in self-test controller for a WIDTH-bit adder: exhaustively sweeps
// both operands, compares each result against a golden modulo sum, and
// reports pass/fail with capture of the first failing vector.
module adder_bist
  import adder_bist_pkg::*;
#(
  parameter int WIDTH         = DEF_WIDTH,
  parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [WIDTH-1:0] operand0,
  output logic [WIDTH-1:0] operand1,
  input  logic [WIDTH-1:0] result,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             fail,
  output logic [WIDTH-1:0] err_operand0,
  output logic [WIDTH-1:0] err_operand1,
  output logic [WIDTH-1:0] err_result,
  output logic [WIDTH-1:0] err_expected
);

  // The wait counter only has to hold SETTLE_CYCLES-1.
  localparam int                CNT_W     = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0]  WAIT_LOAD = CNT_W'(SETTLE_CYCLES - 1);

  // Golden model: carry-out is deliberately dropped so it matches a WIDTH-bit adder.
  function automatic logic [WIDTH-1:0] golden_sum(input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b);
    logic [WIDTH:0] full;
    full = {1'b0, a} + {1'b0, b};
    return full[WIDTH-1:0];
  endfunction

  bist_state_e      state_d, state_q;
  logic [CNT_W-1:0] wait_d, wait_q;
  logic             busy_d, busy_q;
  logic             done_d, done_q;
  logic             pass_d, pass_q;
  logic             fail_d, fail_q;
  logic [WIDTH-1:0] err_op0_d, err_op0_q;
  logic [WIDTH-1:0] err_op1_d, err_op1_q;
  logic [WIDTH-1:0] err_res_d, err_res_q;
  logic [WIDTH-1:0] err_exp_d, err_exp_q;

  logic             sweep_clear;
  logic             sweep_advance;
  logic             sweep_last;
  logic [WIDTH-1:0] sweep_op0;
  logic [WIDTH-1:0] sweep_op1;
  logic [WIDTH-1:0] expected;

  adder_bist_sweep #(
    .WIDTH (WIDTH)
  ) u_sweep (
    .clk      (clk),
    .rst      (rst),
    .clear    (sweep_clear),
    .advance  (sweep_advance),
    .operand0 (sweep_op0),
    .operand1 (sweep_op1),
    .last     (sweep_last)
  );

  assign expected = golden_sum(sweep_op0, sweep_op1);

  // FSM next-state, wait counter, comparator and first-error capture.
  always_comb begin
    state_d       = state_q;
    wait_d        = wait_q;
    pass_d        = pass_q;
    fail_d        = fail_q;
    err_op0_d     = err_op0_q;
    err_op1_d     = err_op1_q;
    err_res_d     = err_res_q;
    err_exp_d     = err_exp_q;
    sweep_clear   = 1'b0;
    sweep_advance = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        // Restart from DONE needs no idle gap: status clears on the start edge.
        if (start) begin
          sweep_clear = 1'b1;
          pass_d      = 1'b0;
          fail_d      = 1'b0;
          err_op0_d   = '0;
          err_op1_d   = '0;
          err_res_d   = '0;
          err_exp_d   = '0;
          wait_d      = WAIT_LOAD;
          state_d     = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (wait_q == '0) begin
          state_d = ST_CHECK;
        end else begin
          wait_d = wait_q - CNT_W'(1);
        end
      end
      ST_CHECK: begin
        if (result != expected) begin
          // Operands are left at the failing vector for board-level inspection.
          err_op0_d = sweep_op0;
          err_op1_d = sweep_op1;
          err_res_d = result;
          err_exp_d = expected;
          fail_d    = 1'b1;
          state_d   = ST_DONE;
        end else if (sweep_last) begin
          pass_d  = 1'b1;
          state_d = ST_DONE;
        end else begin
          sweep_advance = 1'b1;
          wait_d        = WAIT_LOAD;
          state_d       = ST_WAIT;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d == ST_WAIT) || (state_d == ST_CHECK);
    done_d = (state_d == ST_DONE);
  end

  // State and status registers; outputs come straight from these flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      wait_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      fail_q    <= 1'b0;
      err_op0_q <= '0;
      err_op1_q <= '0;
      err_res_q <= '0;
      err_exp_q <= '0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      pass_q    <= pass_d;
      fail_q    <= fail_d;
      err_op0_q <= err_op0_d;
      err_op1_q <= err_op1_d;
      err_res_q <= err_res_d;
      err_exp_q <= err_exp_d;
    end
  end

  assign operand0     = sweep_op0;
  assign operand1     = sweep_op1;
  assign busy         = busy_q;
  assign done         = done_q;
  assign pass         = pass_q;
  assign fail         = fail_q;
  assign err_operand0 = err_op0_q;
  assign err_operand1 = err_op1_q;
  assign err_result   = err_res_q;
  assign err_expected = err_exp_q;

endmodule
